// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: fully registered bitonic sorting network with valid/ready flow control.
// Each vector carries a direction tag that flips every compare-exchange it meets.
module bitonic_sort_pipe #(
  parameter int DSIZE = 18,
  parameter int OFFSET = 8,
  parameter int LOG2N = 3,
  localparam int N = 1 << LOG2N,
  localparam int S = LOG2N * (LOG2N + 1) / 2,
  localparam int CW = $clog2(S + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dir,
  input  logic [N*DSIZE-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dir,
  output logic [N*DSIZE-1:0] out_data,
  output logic [CW-1:0]     occupancy,
  output logic              busy
);
  logic [DSIZE-1:0] data_q [S][N];
  logic [DSIZE-1:0] data_d [S][N];
  logic [DSIZE-1:0] col_in [S][N];
  logic vld_q [S];
  logic vld_d [S];
  logic dir_q [S];
  logic dir_d [S];
  logic [CW-1:0] occ_q, occ_d;
  logic adv, in_hs, out_hs;
  assign adv = !vld_q[S-1] || out_ready;
  assign in_ready = adv;
  assign in_hs = in_valid && adv;
  assign out_hs = vld_q[S-1] && out_ready;
  assign out_valid = vld_q[S-1];
  assign out_dir = dir_q[S-1];
  assign occupancy = occ_q;
  assign busy = occ_q != '0;
  assign occ_d = occ_q + CW'(in_hs) - CW'(out_hs);
  always_comb begin
    out_data = '0;
    for (int e = 0; e < N; e++) out_data[e*DSIZE +: DSIZE] = data_q[S-1][e];
  end
  for (genvar s = 0; s < S; s++) begin : g_in
    if (s == 0) begin : g_first
      assign vld_d[0] = in_valid;
      assign dir_d[0] = in_dir;
      for (genvar e = 0; e < N; e++) begin : g_e
        assign col_in[0][e] = in_data[e*DSIZE +: DSIZE];
      end
    end else begin : g_rest
      assign vld_d[s] = vld_q[s-1];
      assign dir_d[s] = dir_q[s-1];
      for (genvar e = 0; e < N; e++) begin : g_e
        assign col_in[s][e] = data_q[s-1][e];
      end
    end
  end
  // Phase p merges runs of 2^p; column q compares elements 2^(p-1-q) apart.
  for (genvar p = 1; p <= LOG2N; p++) begin : g_phase
    for (genvar q = 0; q < p; q++) begin : g_col
      localparam int ST = p * (p - 1) / 2 + q;
      localparam int D = 1 << (p - 1 - q);
      for (genvar e = 0; e < N; e++) begin : g_ce
        if ((e & D) == 0) begin : g_pair
          logic up, swap;
          logic [DSIZE-1:0] a, b;
          assign a = col_in[ST][e];
          assign b = col_in[ST][e+D];
          assign up = ((e & (1 << p)) == 0) != dir_d[ST];
          assign swap = up ? a[DSIZE-1:OFFSET] > b[DSIZE-1:OFFSET]
                           : a[DSIZE-1:OFFSET] < b[DSIZE-1:OFFSET];
          assign data_d[ST][e] = swap ? b : a;
          assign data_d[ST][e+D] = swap ? a : b;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      for (int s = 0; s < S; s++) begin
        vld_q[s] <= 1'b0;
        dir_q[s] <= 1'b0;
        for (int e = 0; e < N; e++) data_q[s][e] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      if (adv) begin
        vld_q <= vld_d;
        dir_q <= dir_d;
        data_q <= data_d;
      end
    end
  end
endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// tb_bitonic_sort_pipe: scoreboard bench; a monitor checks every output vector against a sort-based model.
module tb_bitonic_sort_pipe;
  localparam int DSIZE = 18;
  localparam int OFFSET = 8;
  localparam int LOG2N = 3;
  localparam int N = 8;
  localparam int CW = 3;
  localparam int W = N * DSIZE;
  localparam int W1 = W + 1;
  typedef struct packed {
    logic dir;
    logic [W-1:0] data;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_dir = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_dir, busy;
  logic [W-1:0] out_data;
  logic [CW-1:0] occupancy;
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  int occ_max = 0;
  bit done = 1'b0;
  bitonic_sort_pipe #(.DSIZE(DSIZE), .OFFSET(OFFSET), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .out_data(out_data), .occupancy(occupancy), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask
  function automatic logic [DSIZE-OFFSET-1:0] key(input logic [DSIZE-1:0] w);
    return w[DSIZE-1:OFFSET];
  endfunction
  // Model: expected keys are the input keys sorted; the words must be a permutation of the input.
  task automatic check_vec(input vec_t exp, input logic dir, input logic [W-1:0] data);
    logic [DSIZE-1:0] ref_w[$];
    logic [DSIZE-1:0] got_w[$];
    logic [DSIZE-OFFSET-1:0] keys[$];
    logic [W-1:0] ref_p, got_p;
    for (int i = 0; i < N; i++) begin
      ref_w.push_back(exp.data[i*DSIZE +: DSIZE]);
      got_w.push_back(data[i*DSIZE +: DSIZE]);
      keys.push_back(key(exp.data[i*DSIZE +: DSIZE]));
    end
    if (exp.dir) keys.rsort();
    else keys.sort();
    for (int i = 0; i < N; i++) begin
      ref_p[i*DSIZE +: DSIZE] = DSIZE'(keys[i]);
      got_p[i*DSIZE +: DSIZE] = DSIZE'(key(got_w[i]));
    end
    chk("out_dir", W1'(dir), W1'(exp.dir));
    chk("key_order", W1'(got_p), W1'(ref_p));
    ref_w.sort();
    got_w.sort();
    for (int i = 0; i < N; i++) begin
      ref_p[i*DSIZE +: DSIZE] = ref_w[i];
      got_p[i*DSIZE +: DSIZE] = got_w[i];
    end
    chk("permutation", W1'(got_p), W1'(ref_p));
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      chk("occupancy", W1'(occupancy), W1'(sb.size()));
      chk("busy", W1'(busy), W1'(sb.size() != 0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h want none", out_data);
        end else check_vec(sb.pop_front(), out_dir, out_data);
      end
    end
  end
  task automatic send(input logic [W-1:0] d, input logic dir);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_dir = dir;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) sb.push_back({dir, d});
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 want handshake");
    end
  endtask
  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] d;
    logic [9:0] k;
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(0, 1) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      d[i*DSIZE +: DSIZE] = {k, 8'($urandom)};
    end
    return d;
  endfunction
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", W1'(sb.size()), W1'(0));
    @(posedge clk);
    #1;
  endtask
  task automatic directed(input logic dir);
    int ks[8] = '{7, 3, 5, 1, 6, 0, 4, 2};
    int pa[8] = '{5, 3, 7, 1, 6, 2, 4, 0};
    int pd[8] = '{0, 4, 2, 6, 1, 7, 3, 5};
    logic [W-1:0] d, e;
    for (int i = 0; i < N; i++) begin
      d[i*DSIZE +: DSIZE] = {10'(ks[i]), 8'(i)};
      e[i*DSIZE +: DSIZE] = dir ? {10'(7 - i), 8'(pd[i])} : {10'(i), 8'(pa[i])};
    end
    send(d, dir);
    in_valid = 1'b0;
    chk("occ_in_flight", W1'(occupancy), W1'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("early_valid", W1'(out_valid), W1'(0));
    @(negedge clk);
    chk("latency_valid", W1'(out_valid), W1'(1));
    chk("directed_dir", W1'(out_dir), W1'(dir));
    chk("directed_data", W1'(out_data), W1'(e));
    @(posedge clk);
    #1;
    chk("occ_after", W1'(occupancy), W1'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] snap, d;
    #22 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W1'(out_valid), W1'(0));
    chk("rst_in_ready", W1'(in_ready), W1'(1));
    chk("rst_out_data", W1'(out_data), W1'(0));
    chk("rst_out_dir", W1'(out_dir), W1'(0));
    @(posedge clk);
    #1;
    directed(1'b0);
    directed(1'b1);
    occ_max = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_vec(), 1'(i));
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        snap = out_data;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", W1'(in_ready), W1'(0));
          chk("stall_stable", W1'(out_data), W1'(snap));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("occ_peak", W1'(occ_max), W1'(6));
    for (int i = 0; i < N; i++) d[i*DSIZE +: DSIZE] = {10'd9, 8'(i)};
    send(d, 1'b0);
    idle(1);
    wait_drain();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(rand_vec(), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_vec(), 1'(i));
    in_valid = 1'b0;
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk("pre_rst_valid", W1'(out_valid), W1'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", W1'(out_valid), W1'(0));
    chk("midrst_occ", W1'(occupancy), W1'(0));
    chk("midrst_busy", W1'(busy), W1'(0));
    chk("midrst_data", W1'(out_data), W1'(0));
    sb.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(20);
    @(negedge clk);
    chk("post_rst_valid", W1'(out_valid), W1'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
Parametrised, pipelined bitonic sorter for 2^LOG2N words of DSIZE bits. It orders each word by its key field [DSIZE-1:OFFSET]; the low OFFSET bits are payload (symbol index) and travel with the key.
Every compare stage is registered. Input and output use valid/ready handshakes with backpressure, and each vector carries a direction tag (ascending or descending).
It is the streaming successor to the fixed-size combinational sort networks, and feeds the Huffman tree builder at one vector per clock.

Parameters:
DSIZE, 18, word width (key plus payload).
OFFSET, 8, payload width; key = bits [DSIZE-1:OFFSET]; legal range 0..DSIZE-1.
LOG2N, 3, log2 of element count N; legal range 1..5.
Derived (localparams, not overridable):
- N = 2^LOG2N.
- S = LOG2N*(LOG2N+1)/2, the number of pipeline stages (6 for N=8).
- CW = clog2(S+1).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input vector present.
in_ready  out  1  sorter accepts the input vector this cycle.
in_dir  in  1  0 = ascending (element 0 holds the smallest key), 1 = descending.
in_data  in  N*DSIZE  element i at [i*DSIZE +: DSIZE].
out_valid  out  1  sorted vector present.
out_ready  in  1  downstream accepts the output.
out_dir  out  1  direction tag of the vector on out_data.
out_data  out  N*DSIZE  sorted vector, same element packing as in_data.
occupancy  out  CW  number of valid vectors held in the pipeline.
busy  out  1  high when occupancy != 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits, data registers and dir tags clear to 0.
  - Outputs: out_valid=0, out_data=0, out_dir=0, occupancy=0, busy=0.
  - in_ready=1 once reset is released.
- Network:
  - Standard bitonic sort: LOG2N merge phases; phase p has p compare-exchange columns; S columns in total.
  - Every column is followed by a register holding data, valid and dir.
  - The per-element compare direction is the network direction XOR the dir bit carried with the vector.
- Compare-exchange:
  - Unsigned compare of key fields only.
  - Full words are swapped, so payload stays attached to its key.
  - On equal keys, no swap.
- Ordering guarantees:
  - The output key sequence is non-decreasing (dir=0) or non-increasing (dir=1).
  - The output is a permutation of the input words.
  - Order among equal keys is unspecified.
- Flow control (global pipeline enable):
  - adv = !out_valid || out_ready, and in_ready = adv. This is a combinational path from out_ready to in_ready.
  - When adv=1 all stages shift one position. Stage 1 captures in_data/in_dir and takes valid = in_valid.
  - When adv=0 all stage registers hold.
  - Bubbles are not collapsed.
- Latency:
  - A vector accepted at edge t is on out_data with out_valid=1 after edge t+S-1, provided adv stayed 1.
  - Each cycle with adv=0 adds one cycle.
  - Throughput is one vector per clock while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_dir hold stable.
- occupancy:
  - +1 on an input handshake; -1 on an output handshake; unchanged when both or neither occur.
  - Never exceeds S.
- in_valid=0 while adv=1: a bubble enters stage 1, and its data is don't-care.
- Reset mid-operation: all in-flight vectors are discarded, with no partial output.
- LOG2N=1: S=1, a single registered compare-exchange with the same handshake.

Test Plan:
1. Reset, then idle -> out_valid=0, occupancy=0, busy=0, in_ready=1, out_data=0.
2. Ascending sort, N=8, DSIZE=18, OFFSET=8, out_ready=1:
   - Stimulus: element i = {key,i} with keys 7,3,5,1,6,0,4,2 and in_dir=0.
   - Response: after 5 further edges, out keys are 0..7 with payloads 5,3,7,1,6,2,4,0; out_dir=0.
   - occupancy is 1 during flight and 0 after the output handshake.
3. Descending sort: same vector with in_dir=1 -> keys 7..0 with payloads 0,4,2,6,1,7,3,5; out_dir=1.
4. Backpressure:
   - Stimulus: stream 8 random vectors back-to-back with alternating dir; hold out_ready=0 for 3 cycles once out_valid rises.
   - Response: in_ready=0 during the stall; out_data stable; occupancy peaks at 6.
   - All 8 vectors emerge in order, each correctly sorted against a scoreboard; no loss or duplication.
5. Duplicate keys: all keys =9 with payloads 0..7 -> all output keys =9, and the payload set is exactly {0..7}.
6. Reset mid-flight: 3 vectors in pipeline, pulse rst asynchronously between edges -> out_valid drops immediately, occupancy=0, and no stale vector appears afterwards.
